fir_filter_tdm: RTL
===================

// Module: fir_filter_tdm
// PURPOSE
//  Parametrised, time-multiplexed FIR filter; next-generation replacement for the fixed filter
//  stage that follows the phase accumulator / phase-to-amplitude sine source.
//  One shared multiply-accumulate unit processes all taps serially. Coefficients are runtime-loadable.
//  Valid/ready handshake on input, single-cycle valid pulse on output.
//  Selectable signed or unsigned (offset-binary) input, so the 10-bit sine source connects directly.
// PARAMETERS
//  DATA_W     10  input sample width
//  COEF_W     8   signed coefficient width
//  TAPS       4   number of taps (>=2)
//  SIGNED_IN  0   0: input is offset-binary unsigned; 1: input is two's complement
//  ACC_W      DATA_W+COEF_W+$clog2(TAPS)   output/accumulator width (derived, not overridden)
// PORTS
//  clock      in   1                clock, all state changes on its rising edge
//  reset      in   1                asynchronous, active-low reset
//  coef_we    in   1                coefficient write strobe
//  coef_addr  in   $clog2(TAPS)     coefficient index (tap k)
//  coef_data  in   COEF_W           signed coefficient value
//  in_valid   in   1                input sample valid
//  in_ready   out  1                filter can accept a sample this cycle
//  in_data    in   DATA_W           input sample
//  out_valid  out  1                one-cycle pulse, out_data is a new result
//  out_data   out  ACC_W            signed filtered output
//  busy       out  1                MAC sequence in progress
// BEHAVIOUR
//  Reset (reset=0, async): state IDLE; delay line x[0..TAPS-1]=0; coefficients h[]=0; acc=0;
//   out_data=0; out_valid=0; busy=0; in_ready=1. Reset mid-sequence aborts it; no out_valid is issued.
//  Sample conversion: SIGNED_IN=0 gives x = {~in_data[MSB], in_data[MSB-1:0]} (512 maps to 0).
//   SIGNED_IN=1 uses in_data as-is.
//  FSM states:
//   IDLE: in_ready=1, busy=0.
//    On in_valid && in_ready: shift the converted sample into x[0] (x[k] <= x[k-1]), acc<=0, k<=0, go to MAC.
//   MAC: in_ready=0, busy=1. Each cycle acc += x[k]*h[k], k++.
//    On the edge processing k=TAPS-1: out_data <= acc + x[k]*h[k], out_valid<=1, go to IDLE.
//  Timing: latency is TAPS edges from the accept edge to the out_valid cycle.
//   Maximum throughput is one sample per TAPS+1 cycles. in_ready=1 in the same cycle out_valid=1.
//  out_valid is high for exactly one cycle. out_data holds its value until the next result.
//  Arithmetic: products are signed DATA_W+COEF_W bits, sign-extended to ACC_W. Full precision;
//   no rounding, truncation or saturation. Overflow is impossible by construction.
//  Coefficient writes: accepted only when busy=0; ignored while busy. coef_addr>=TAPS is ignored.
//  Write and accept in the same IDLE cycle: both occur, and the new h[] is used for that sample.
//  in_valid while in_ready=0: not consumed; the source must hold in_data until in_ready.
// STRUCTURE
//  Shared package/include fir_pkg: FSM state encodings (IDLE, MAC), ACC_W derivation macro/function,
//   offset-binary conversion function.
//  Sub-module fir_mac: registered signed multiply-accumulate with synchronous clear and enable.
//   fir_filter_tdm owns the FSM, tap counter, delay line and coefficient register file.
// TESTING (DATA_W=10, COEF_W=8, TAPS=4, ACC_W=20)
//  1 Reset: assert reset=0 mid-run -> out_valid=0, out_data=0, in_ready=1, busy=0 immediately.
//  2 Impulse, SIGNED_IN=1: h=[1,2,3,4]; inputs 100,0,0,0,0 -> out 100,200,300,400,0.
//    Each out_valid comes 4 edges after accept.
//  3 Offset-binary, SIGNED_IN=0: h=[1,0,0,0]; input 512 -> out 0; input 1023 -> 511; input 0 -> -512.
//  4 Extremes: h all -128; four inputs of -512 -> final out = 262144, no wrap.
//    h all 127 with -512 inputs -> out = -260096.
//  5 Handshake: hold in_valid=1 continuously -> accepts spaced 5 cycles, in_ready=0 while busy.
//    coef_we during busy -> h unchanged (verified by the next output).
//  6 Abort: reset=0 for 1 cycle at MAC k=2 -> no out_valid.
//    The delay line is cleared: the next impulse of 100 with h=[1,2,3,4] gives 100 first.

Source files
------------

// File: rtl/fir_pkg.sv
// fir_pkg: shared definitions for the time-multiplexed FIR filter.
//   fir_state_t     - controller states (IDLE waits for a sample, MAC runs the taps)
//   acc_width()     - accumulator/output width for a given data, coefficient and tap count
//   offset_to_twos()- offset-binary to two's complement conversion (inverts bit w-1)
package fir_pkg;

    typedef enum logic {
        IDLE,
        MAC
    } fir_state_t;

    // Room for TAPS full-precision products, so the running sum can never wrap.
    function automatic int acc_width(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + $clog2(taps);
    endfunction

    // Offset binary maps mid-scale to zero by flipping the MSB of a w-bit value.
    function automatic logic [31:0] offset_to_twos(input logic [31:0] d, input int unsigned w);
        return d ^ (32'd1 << (w - 1));
    endfunction

endpackage

// File: rtl/fir_mac.sv
// fir_mac: registered signed multiply-accumulate.
//   clock, reset : rising-edge clock, asynchronous active-low reset
//   clear        : synchronous clear of the accumulator (has priority over enable)
//   enable       : acc <= acc + a*b
//   a, b         : signed operands (A_W, B_W bits)
//   sum          : combinational acc + a*b, so the caller can capture the final total
//                  on the same edge that would otherwise update acc
module fir_mac #(
    parameter int A_W   = 10,
    parameter int B_W   = 8,
    parameter int ACC_W = 20
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [A_W-1:0]   a,
    input  logic [B_W-1:0]   b,
    output logic [ACC_W-1:0] sum
);

    localparam int P_W = A_W + B_W;

    logic signed [P_W-1:0] a_ext;
    logic signed [P_W-1:0] b_ext;
    logic signed [P_W-1:0] prod;
    logic [ACC_W-1:0]      acc;

    // Operands are sign-extended to the full product width first; the exact
    // product always fits in P_W bits, so the truncated multiply is exact.
    always_comb begin
        a_ext = P_W'($signed(a));
        b_ext = P_W'($signed(b));
        prod  = a_ext * b_ext;
        sum   = acc + ACC_W'(prod);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (enable) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/fir_filter_tdm.sv
// fir_filter_tdm: time-multiplexed FIR filter, one shared MAC stepping through all taps.
//   clock, reset         : rising-edge clock, asynchronous active-low reset
//   coef_we/addr/data    : coefficient write port, honoured only while idle
//   in_valid/in_ready    : sample handshake; in_data is offset binary when SIGNED_IN=0
//   out_valid, out_data  : one-cycle result pulse, out_data held until the next result
//   busy                 : MAC sequence in progress
module fir_filter_tdm
    import fir_pkg::*;
#(
    parameter  int DATA_W    = 10,
    parameter  int COEF_W    = 8,
    parameter  int TAPS      = 4,
    parameter  int SIGNED_IN = 0,
    localparam int ACC_W     = acc_width(DATA_W, COEF_W, TAPS),
    localparam int ADDR_W    = $clog2(TAPS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              coef_we,
    input  logic [ADDR_W-1:0] coef_addr,
    input  logic [COEF_W-1:0] coef_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [ACC_W-1:0]  out_data,
    output logic              busy
);

    fir_state_t        state;
    fir_state_t        state_next;
    logic [DATA_W-1:0] x [TAPS];
    logic [COEF_W-1:0] h [TAPS];
    logic [ADDR_W-1:0] k;
    logic [DATA_W-1:0] sample;
    logic [DATA_W-1:0] tap_x;
    logic [COEF_W-1:0] tap_h;
    logic [ACC_W-1:0]  mac_sum;
    logic              accept;
    logic              last;
    logic              coef_ok;

    always_comb begin
        sample  = (SIGNED_IN != 0) ? in_data
                                   : DATA_W'(offset_to_twos(32'(in_data), DATA_W));
        tap_x   = x[k];
        tap_h   = h[k];
        last    = (k == ADDR_W'(TAPS - 1));
        coef_ok = coef_we && (state == IDLE) && (int'(coef_addr) < TAPS);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        accept     = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = MAC;
                end
            end
            MAC: begin
                busy = 1'b1;
                if (last) begin
                    state_next = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            k         <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            for (int unsigned i = 0; i < TAPS; i++) begin
                x[i] <= '0;
                h[i] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            if (coef_ok) begin
                h[coef_addr] <= coef_data;
            end
            if (accept) begin
                x[0] <= sample;
                for (int unsigned i = 1; i < TAPS; i++) begin
                    x[i] <= x[i-1];
                end
                k <= '0;
            end else if (state == MAC) begin
                k <= k + 1'b1;
                // Last tap: take the total straight from the adder, not the register.
                if (last) begin
                    out_data  <= mac_sum;
                    out_valid <= 1'b1;
                end
            end
        end
    end

    fir_mac #(
        .A_W   (DATA_W),
        .B_W   (COEF_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clock  (clock),
        .reset  (reset),
        .clear  (accept),
        .enable (state == MAC),
        .a      (tap_x),
        .b      (tap_h),
        .sum    (mac_sum)
    );

endmodule
